// File: rtl/egg_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : egg_timer_pkg
// Purpose  : Shared state encoding, digit width and BCD step helpers.
// Revision : 1.0
// ============================================================================
package egg_timer_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;

    typedef enum logic [1:0] {
        SET   = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] digit,
                                                 input logic [BCD_W-1:0] limit);
        return (digit >= limit) ? '0 : digit + 4'd1;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] digit,
                                                 input logic [BCD_W-1:0] limit);
        return (digit == '0 || digit > limit) ? limit : digit - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/egg_timer_ctrl_field.sv
`default_nettype none
// ============================================================================
// Module   : bcd_field
// Purpose  : Two-digit BCD field 00..TENS_MAX9 with wrap, load and borrow-out.
// Revision : 1.0
// ============================================================================
module bcd_field
    import egg_timer_pkg::*;
#(
    parameter int TENS_MAX = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_tens,
    input  logic [BCD_W-1:0] i_load_ones,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_ones,
    output logic             o_borrow
);

    localparam logic [BCD_W-1:0] c_tens_max = BCD_W'(TENS_MAX);
    localparam logic [BCD_W-1:0] c_ones_max = 4'd9;

    logic [BCD_W-1:0] r_tens;
    logic [BCD_W-1:0] r_ones;
    logic             w_step_up;
    logic             w_step_dn;

    // Opposing requests on the same field cancel out.
    assign w_step_up = i_inc & ~i_dec;
    assign w_step_dn = i_dec & ~i_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_load) begin
            r_tens <= i_load_tens;
            r_ones <= i_load_ones;
        end else if (w_step_up) begin
            r_ones <= bcd_inc(r_ones, c_ones_max);
            if (r_ones == c_ones_max)
                r_tens <= bcd_inc(r_tens, c_tens_max);
        end else if (w_step_dn) begin
            r_ones <= bcd_dec(r_ones, c_ones_max);
            if (r_ones == '0)
                r_tens <= bcd_dec(r_tens, c_tens_max);
        end
    end

    assign o_tens   = r_tens;
    assign o_ones   = r_ones;
    assign o_borrow = w_step_dn & (r_tens == '0) & (r_ones == '0);

endmodule
`default_nettype wire

// File: rtl/egg_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : egg_timer_ctrl
// Purpose  : MM:SS BCD countdown egg timer with set/run/pause/alarm modes.
// Revision : 1.0
// ============================================================================
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5,
    parameter int ALARM_LEN    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic             min_up,
    input  logic             min_down,
    input  logic             sec_up,
    input  logic             sec_down,
    input  logic             start_pause,
    input  logic             clear,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             paused,
    output logic             alarm,
    output logic             done
);

    localparam logic [7:0] c_alarm_len = 8'(ALARM_LEN);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_alarm_cnt;
    logic [4*BCD_W-1:0] r_preset;
    logic               r_running;
    logic               r_paused;
    logic               r_alarm;
    logic               r_done;

    logic [4*BCD_W-1:0] w_time;
    logic [4*BCD_W-1:0] w_load_val;
    logic               w_nonzero;
    logic               w_last_sec;
    logic               w_illegal;
    logic               w_set_btn;
    logic               w_run_tick;
    logic               w_alarm_tick;
    logic               w_alarm_end;
    logic               w_reload;
    logic               w_load;
    logic               w_sec_borrow;

    assign w_time     = {min_tens, min_ones, sec_tens, sec_ones};
    assign w_nonzero  = |w_time;
    assign w_last_sec = (w_time == 16'h0001);
    assign w_illegal  = !(r_state inside {SET, RUN, PAUSE, ALARM});

    // A start with a nonzero time consumes the cycle; otherwise buttons apply.
    assign w_set_btn    = (r_state == SET) & ~clear & ~(start_pause & w_nonzero);
    assign w_run_tick   = (r_state == RUN) & ~clear & ~start_pause & tick_1hz;
    assign w_alarm_tick = (r_state == ALARM) & ~clear & ~start_pause & tick_1hz;
    assign w_alarm_end  = w_alarm_tick & ((r_alarm_cnt + 8'd1) == c_alarm_len);
    assign w_reload     = ((r_state == ALARM) & ~clear & start_pause) | w_alarm_end;
    assign w_load       = clear | w_reload | w_illegal;
    assign w_load_val   = w_reload ? r_preset : '0;

    bcd_field #(.TENS_MAX(SEC_TENS_MAX)) u_sec (
        .clk         (clk),
        .rst         (reset),
        .i_inc       (w_set_btn & sec_up),
        .i_dec       ((w_set_btn & sec_down) | w_run_tick),
        .i_load      (w_load),
        .i_load_tens (w_load_val[7:4]),
        .i_load_ones (w_load_val[3:0]),
        .o_tens      (sec_tens),
        .o_ones      (sec_ones),
        .o_borrow    (w_sec_borrow)
    );

    // Seconds borrow feeds minutes only while counting down.
    bcd_field #(.TENS_MAX(MIN_TENS_MAX)) u_min (
        .clk         (clk),
        .rst         (reset),
        .i_inc       (w_set_btn & min_up),
        .i_dec       ((w_set_btn & min_down) | (w_run_tick & w_sec_borrow)),
        .i_load      (w_load),
        .i_load_tens (w_load_val[15:12]),
        .i_load_ones (w_load_val[11:8]),
        .o_tens      (min_tens),
        .o_ones      (min_ones),
        .o_borrow    ()
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            SET: begin
                if (!clear && start_pause && w_nonzero)
                    w_next = RUN;
            end
            RUN: begin
                if (clear)
                    w_next = SET;
                else if (start_pause)
                    w_next = PAUSE;
                else if (tick_1hz && w_last_sec)
                    w_next = ALARM;
            end
            PAUSE: begin
                if (clear)
                    w_next = SET;
                else if (start_pause)
                    w_next = RUN;
            end
            ALARM: begin
                if (clear || start_pause || w_alarm_end)
                    w_next = SET;
            end
            default: w_next = SET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SET;
            r_alarm_cnt <= '0;
            r_preset    <= '0;
            r_running   <= 1'b0;
            r_paused    <= 1'b0;
            r_alarm     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_running <= (w_next == RUN);
            r_paused  <= (w_next == PAUSE);
            r_alarm   <= (w_next == ALARM);
            r_done    <= (r_state == RUN) && (w_next == ALARM);
            if (r_state != ALARM)
                r_alarm_cnt <= '0;
            else if (w_alarm_tick)
                r_alarm_cnt <= r_alarm_cnt + 8'd1;
            if (r_state == SET && w_next == RUN)
                r_preset <= w_time;
        end
    end

    assign running = r_running;
    assign paused  = r_paused;
    assign alarm   = r_alarm;
    assign done    = r_done;

endmodule
`default_nettype wire
